// File: rtl/uart_rx_buf_ctl_if.sv
// Host-side read/status port of the UART receive controller.
// The host drives rd/clr_err; the controller drives the FIFO head, occupancy, flow control and sticky errors.
interface uart_rx_buf_ctl_if #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic              rd;
  logic              clr_err;
  logic [DATA_W-1:0] dout;
  logic              empty;
  logic              full;
  logic [LVL_W-1:0]  level;
  logic              flow_ctl;
  logic              frame_err;
  logic              overrun;
  logic              parity_err;

  modport master (
    output rd, clr_err,
    input  dout, empty, full, level, flow_ctl, frame_err, overrun, parity_err
  );

  modport slave (
    input  rd, clr_err,
    output dout, empty, full, level, flow_ctl, frame_err, overrun, parity_err
  );
endinterface

// File: rtl/uart_rx_buf_ctl.sv
// Oversampled UART receiver feeding a first-word-fall-through FIFO with hysteretic flow control.
// Define RX_PARITY_EN to receive one even-parity bit after the data bits.
module uart_rx_buf_ctl #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int OVS        = 16,
  parameter int RTS_HI     = 12,
  parameter int RTS_LO     = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic baud_tick,
  input  logic rxd,
  uart_rx_buf_ctl_if.slave host
);

  localparam int TW = $clog2(OVS);
  localparam int BW = $clog2(DATA_W);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;

  localparam logic [TW-1:0] TICK_MID  = TW'(OVS / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVS - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);
  localparam logic [LW-1:0] DEPTH_L   = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] RTS_HI_L  = LW'(RTS_HI);
  localparam logic [LW-1:0] RTS_LO_L  = LW'(RTS_LO);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef RX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } state_t;

  // ---------------- input synchroniser ----------------
  logic       rxd_meta_reg;
  logic       rxd_sync_reg;
  logic [1:0] sync_fill_reg;

  // sync_fill marks when both stages hold real line samples rather than reset values,
  // so a line held low across reset release never looks like an idle-high line.
  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_meta_reg  <= 1'b1;
      rxd_sync_reg  <= 1'b1;
      sync_fill_reg <= 2'b00;
    end else begin
      rxd_meta_reg  <= rxd;
      rxd_sync_reg  <= rxd_meta_reg;
      sync_fill_reg <= {sync_fill_reg[0], 1'b1};
    end
  end

  // ---------------- deframer FSM ----------------
  state_t            state_reg;
  logic [TW-1:0]     tick_cnt_reg;
  logic [BW-1:0]     bit_cnt_reg;
  logic [DATA_W-1:0] shift_reg;
  logic              armed_reg;

  logic tick_last;
  logic stop_sample;
  logic push;
  logic frame_set;
  logic parity_set;

  assign tick_last   = (tick_cnt_reg == TICK_LAST);
  assign stop_sample = (state_reg == ST_STOP) && baud_tick && tick_last;
  assign push        = stop_sample && rxd_sync_reg;
  assign frame_set   = stop_sample && !rxd_sync_reg;

`ifdef RX_PARITY_EN
  assign parity_set  = (state_reg == ST_PARITY) && baud_tick && tick_last &&
                       (rxd_sync_reg != (^shift_reg));
`else
  assign parity_set  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      tick_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      armed_reg    <= 1'b0;
    end else begin
      if (sync_fill_reg[1] && rxd_sync_reg)
        armed_reg <= 1'b1;

      if (baud_tick) begin
        case (state_reg)
          ST_IDLE: begin
            tick_cnt_reg <= '0;
            if (armed_reg && !rxd_sync_reg)
              state_reg <= ST_START;
          end

          ST_START: begin
            if (tick_cnt_reg == TICK_MID) begin
              tick_cnt_reg <= '0;
              bit_cnt_reg  <= '0;
              state_reg    <= rxd_sync_reg ? ST_IDLE : ST_DATA;
            end else begin
              tick_cnt_reg <= tick_cnt_reg + 1'b1;
            end
          end

          ST_DATA: begin
            if (tick_last) begin
              tick_cnt_reg <= '0;
              shift_reg    <= {rxd_sync_reg, shift_reg[DATA_W-1:1]};
              if (bit_cnt_reg == BIT_LAST) begin
                bit_cnt_reg <= '0;
`ifdef RX_PARITY_EN
                state_reg   <= ST_PARITY;
`else
                state_reg   <= ST_STOP;
`endif
              end else begin
                bit_cnt_reg <= bit_cnt_reg + 1'b1;
              end
            end else begin
              tick_cnt_reg <= tick_cnt_reg + 1'b1;
            end
          end

`ifdef RX_PARITY_EN
          ST_PARITY: begin
            if (tick_last) begin
              tick_cnt_reg <= '0;
              state_reg    <= ST_STOP;
            end else begin
              tick_cnt_reg <= tick_cnt_reg + 1'b1;
            end
          end
`endif

          ST_STOP: begin
            if (tick_last) begin
              tick_cnt_reg <= '0;
              state_reg    <= ST_IDLE;
              // A low stop bit is treated as a break: wait for the line to return high.
              if (!rxd_sync_reg)
                armed_reg <= 1'b0;
            end else begin
              tick_cnt_reg <= tick_cnt_reg + 1'b1;
            end
          end

          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

  // ---------------- receive FIFO ----------------
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_reg;
  logic [AW-1:0]     rd_ptr_reg;
  logic [LW-1:0]     count_reg;
  logic [DATA_W-1:0] dout_reg;
  logic              flow_ctl_reg;

  logic              empty;
  logic              full;
  logic              do_pop;
  logic              do_push;
  logic              overrun_set;
  logic [LW-1:0]     count_next;
  logic [AW-1:0]     rd_ptr_next;
  logic              head_is_new;

  assign empty       = (count_reg == '0);
  assign full        = (count_reg == DEPTH_L);
  assign do_pop      = host.rd && !empty;
  assign do_push     = push && (!full || do_pop);
  assign overrun_set = push && full && !do_pop;
  assign count_next  = count_reg + LW'(do_push) - LW'(do_pop);
  assign rd_ptr_next = rd_ptr_reg + AW'(do_pop);
  // Nothing left behind the head after this cycle's pop: the pushed word becomes the head.
  assign head_is_new = ((count_reg - LW'(do_pop)) == '0);

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr_reg] <= shift_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      dout_reg     <= '0;
      flow_ctl_reg <= 1'b0;
    end else begin
      if (do_push)
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;

      if (count_next != '0) begin
        if (head_is_new)
          dout_reg <= shift_reg;
        else
          dout_reg <= mem[rd_ptr_next];
      end

      if (count_next >= RTS_HI_L)
        flow_ctl_reg <= 1'b1;
      else if (count_next <= RTS_LO_L)
        flow_ctl_reg <= 1'b0;
    end
  end

  // ---------------- sticky error flags ----------------
  logic frame_err_reg;
  logic overrun_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      frame_err_reg <= frame_set   || (frame_err_reg && !host.clr_err);
      overrun_reg   <= overrun_set || (overrun_reg   && !host.clr_err);
    end
  end

`ifdef RX_PARITY_EN
  logic parity_err_reg;

  always_ff @(posedge clk) begin
    if (rst)
      parity_err_reg <= 1'b0;
    else
      parity_err_reg <= parity_set || (parity_err_reg && !host.clr_err);
  end

  assign host.parity_err = parity_err_reg;
`else
  logic unused_parity;
  assign unused_parity   = parity_set;
  assign host.parity_err = 1'b0;
`endif

  assign host.dout      = dout_reg;
  assign host.empty     = empty;
  assign host.full      = full;
  assign host.level     = count_reg;
  assign host.flow_ctl  = flow_ctl_reg;
  assign host.frame_err = frame_err_reg;
  assign host.overrun   = overrun_reg;

endmodule
